// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio output path: mixer FSM states,
// offset-binary <-> two's complement conversion and width-parameterised clamping.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_MASTER = 2'd2,
    ST_OUT    = 2'd3
  } mix_state_e;

  // Offset binary and two's complement differ only in the MSB, so one flip
  // converts in either direction. Bits above w-1 pass through untouched.
  function automatic logic [31:0] flip_msb(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = v;
    r[w[4:0] - 5'd1] = ~v[w[4:0] - 5'd1];
    return r;
  endfunction

  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator: the carry of an unsigned phase
// accumulator fed with the offset-binary form of the input sample.
module sigma_delta_dac
  import audio_pkg::*;
#(
  parameter int OUTBITS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [OUTBITS-1:0] in,
  output logic                      pdm_out
);

  logic [OUTBITS:0]   pacc_q, pacc_d;
  logic [OUTBITS-1:0] u;
  logic [31:0]        flipped;

  always_comb begin
    flipped = flip_msb(32'(in), OUTBITS);
    u       = flipped[OUTBITS-1:0];
    pacc_d  = {1'b0, pacc_q[OUTBITS-1:0]} + {1'b0, u};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pacc_q <= '0;
    else        pacc_q <= pacc_d;
  end

  assign pdm_out = pacc_q[OUTBITS];

endmodule

// File: rtl/voice_mixer.sv
// Snapshots all voices on sample_strobe, runs one shared multiply-accumulate
// over them, applies master gain, shifts, saturates and feeds the PDM modulator.
module voice_mixer
  import audio_pkg::*;
#(
  parameter int NVOICES  = 4,
  parameter int BITDEPTH = 14,
  parameter int OUTBITS  = 16,
  parameter int SHIFT    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_strobe,
  input  logic [NVOICES*BITDEPTH-1:0]   voices_in,
  input  logic [NVOICES*8-1:0]          voice_volume,
  input  logic [7:0]                    master_volume,
  output logic [OUTBITS-1:0]            sample_out,
  output logic                          sample_valid,
  output logic                          busy,
  output logic                          overrun,
  output logic                          pdm_out
);

  localparam int PW = BITDEPTH + 9;
  localparam int AW = PW + $clog2(NVOICES);
  localparam int SW = AW + 9;
  localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NVOICES - 1);

  mix_state_e                   state_q, state_d;
  logic [NVOICES*BITDEPTH-1:0]  voices_q, voices_d;
  logic [NVOICES*8-1:0]         vols_q, vols_d;
  logic signed [AW-1:0]         acc_q, acc_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic signed [SW-1:0]         scaled_q, scaled_d;
  logic signed [OUTBITS-1:0]    out_q, out_d;
  logic                         valid_q, valid_d;
  logic                         ovr_q, ovr_d;

  logic [BITDEPTH-1:0]          cur_v;
  logic [7:0]                   cur_vol;
  logic [31:0]                  flipped;
  logic signed [BITDEPTH-1:0]   cur_s;
  logic signed [PW-1:0]         prod;
  logic signed [SW-1:0]         shifted;
  logic signed [63:0]           clamped;

  // Datapath for the voice currently selected by idx_q.
  always_comb begin
    cur_v   = voices_q[idx_q*BITDEPTH +: BITDEPTH];
    cur_vol = vols_q[idx_q*8 +: 8];
    flipped = flip_msb(32'(cur_v), BITDEPTH);
    cur_s   = signed'(flipped[BITDEPTH-1:0]);
    prod    = PW'(cur_s) * PW'(signed'({1'b0, cur_vol}));
    shifted = scaled_q >>> SHIFT;
    clamped = sat_w(64'(shifted), OUTBITS);
  end

  always_comb begin
    state_d  = state_q;
    voices_d = voices_q;
    vols_d   = vols_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    scaled_d = scaled_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    ovr_d    = sample_strobe && (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (sample_strobe) begin
          voices_d = voices_in;
          vols_d   = voice_volume;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_d = acc_q + AW'(prod);
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) state_d = ST_MASTER;
      end
      ST_MASTER: begin
        scaled_d = SW'(acc_q) * SW'(signed'({1'b0, master_volume}));
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        out_d   = signed'(clamped[OUTBITS-1:0]);
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      voices_q <= '0;
      vols_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      scaled_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      voices_q <= voices_d;
      vols_q   <= vols_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      scaled_q <= scaled_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sample_out   = out_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q != ST_IDLE);

  sigma_delta_dac #(.OUTBITS(OUTBITS)) u_dac (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (out_q),
    .pdm_out (pdm_out)
  );

endmodule
